// File: rtl/svc_stream_demux_onehot_if.sv
// Handshake bundle for the one-hot stream demux: one source stream in, N sinks out.
// The slave modport is the demux's view; master is the view of whoever drives it.
interface svc_stream_demux_onehot_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic [N-1:0]     s_sel;
  logic [N-1:0]     m_valid;
  logic [N-1:0]     m_ready;
  logic [WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/svc_stream_demux_onehot.sv
// 1-to-N stream router: each beat goes to the one sink its one-hot select names, in strict order.
// Optional saturating drop counter for illegal selects: define SVC_STREAM_DEMUX_DROP_CNT_EN.
module svc_stream_demux_onehot #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  svc_stream_demux_onehot_if.slave       bus,
  output logic                           err,
  output logic [15:0]                    drop_cnt
);

  logic             out_valid;
  logic [N-1:0]     out_sel;
  logic [WIDTH-1:0] out_data;
  logic             skid_valid;
  logic [N-1:0]     skid_sel;
  logic [WIDTH-1:0] skid_data;

  logic s_fire;
  logic sel_ok;
  logic out_fire;
  logic out_open;
  logic take;
  logic drop;

  // s_ready depends only on the skid register, so m_ready never reaches it combinationally
  assign bus.s_ready = !skid_valid;
  assign s_fire      = bus.s_valid & !skid_valid;
  assign sel_ok      = $onehot(bus.s_sel);
  assign take        = s_fire & sel_ok;
  assign drop        = s_fire & !sel_ok;
  assign out_fire    = out_valid & (|(out_sel & bus.m_ready));
  assign out_open    = !out_valid | out_fire;

  assign bus.m_valid = out_sel & {N{out_valid}};
  assign bus.m_data  = out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sel    <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_sel   <= '0;
      skid_data  <= '0;
    end else if (out_open) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_sel    <= skid_sel;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (take) begin
        out_valid <= 1'b1;
        out_sel   <= bus.s_sel;
        out_data  <= bus.s_data;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end else if (take) begin
      skid_valid <= 1'b1;
      skid_sel   <= bus.s_sel;
      skid_data  <= bus.s_data;
    end
  end

  // Illegal-select beats are swallowed on acceptance; err flags each one a cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= drop;
    end
  end

`ifdef SVC_STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 16'd0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: doc/svc_stream_demux_onehot.md
Name: svc_stream_demux_onehot

Overview:
- 1-to-N stream router; the distributing counterpart of the one-hot N-to-1 data mux.
- Takes a valid/ready source stream with a one-hot destination select per beat and delivers each beat to exactly one of N valid/ready sinks.
- Registered output plus a 1-entry skid buffer: full throughput, registered s_ready, in-order delivery.
- Sits in front of per-destination consumers, e.g. fanning a command stream out to N engines.

Parameters:
WIDTH, 32, data bits per beat
N, 4, number of destinations; width of the one-hot select

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
s_valid  in  1  source beat valid
s_ready  out  1  source ready
s_data  in  WIDTH  source beat data
s_sel  in  N  one-hot destination select, qualified by s_valid
m_valid  out  N  per-destination valid; at most one bit set
m_ready  in  N  per-destination ready
m_data  out  WIDTH  beat data, shared by all destinations; meaningful only where m_valid[i]=1
err  out  1  one-cycle pulse: a beat with an illegal select was dropped
drop_cnt  out  16  count of dropped beats (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert as elsewhere in the codebase): out_valid=0, skid_valid=0, m_valid=0, s_ready=1, err=0, drop_cnt=0. m_data and out_sel reset to 0. Beats in flight at reset are discarded.
- Fire definitions:
  - s_fire = s_valid & s_ready.
  - sel_ok = s_sel is exactly one-hot (popcount==1).
  - out_fire = out_valid & |(out_sel & m_ready).
- Outputs:
  - m_valid = out_sel & {N{out_valid}}.
  - m_data = out_data.
  - s_ready = !skid_valid (register-driven, no combinational path from m_ready).
- Each cycle, with out_open = !out_valid | out_fire:
  - out_open & skid_valid: skid -> out; skid_valid=0.
  - out_open & !skid_valid & s_fire & sel_ok: s -> out.
  - out_open & !skid_valid & !(s_fire & sel_ok): out_valid=0 if out_fire.
  - !out_open & s_fire & sel_ok: s -> skid; skid_valid=1.
- Latency: s_fire to m_valid is 1 cycle. Throughput: 1 beat/cycle with an always-ready sink.
- Ordering: strict source order across all destinations. A stalled destination blocks all others (head-of-line blocking is the required behaviour, not a bug).
- Illegal select (s_sel==0 or multi-hot):
  - The beat is still accepted (s_fire), never stored, never presented.
  - err=1 on the following cycle for exactly one cycle.
  - Back-to-back illegal beats give back-to-back err pulses.
- m_ready bits of non-selected destinations are ignored. m_valid/m_data stay stable while the selected m_ready=0.
- Simultaneous events:
  - out_fire with skid full: skid moves to out the same cycle; s_ready returns to 1 the next cycle.
  - out_fire with s_fire while skid empty: new beat goes directly to out; no bubble.
- Full: out and skid both valid, so s_ready=0. Empty: m_valid=0 and s_ready=1.

Optional Feature:
- Macro SVC_STREAM_DEMUX_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 on every illegal-select s_fire, saturating at 16'hFFFF (no wrap). Reset to 0.
- Not defined: drop_cnt is tied to 0 and no counter logic is synthesized. The err pulse is unaffected either way.

Test Plan:
- Reset -> m_valid=0, s_ready=1, err=0, drop_cnt=0.
- All m_ready=1; send 32'hAAAA_AAAA sel 0001, 32'hBBBB_BBBB sel 0010, 32'hCCCC_CCCC sel 0100, 32'hDDDD_DDDD sel 1000 on consecutive cycles -> each appears 1 cycle later on m_valid 0001, 0010, 0100, 1000 with matching m_data; s_ready stays 1.
- m_ready=0000; send 3 beats to sel 0010 -> s_ready=0 after 2 accepted. Then m_ready=0010 -> beats emerge in order, 1/cycle, and the third is accepted.
- Stall dest 0 with head beat for sel 0001, next beat for sel 0100 with m_ready[2]=1 -> sel 0100 beat not delivered until dest 0 accepts.
- Send s_sel=0000, then 0011 (values 32'h1111_1111, 32'h2222_2222) -> no m_valid, err pulses two consecutive cycles; with SVC_STREAM_DEMUX_DROP_CNT_EN drop_cnt=2, without it drop_cnt=0.
- Assert rst_n=0 with out and skid full -> m_valid=0 and s_ready=1 immediately (async); no stale beat after release.
